// File: rtl/wb_bus_t.sv
// Wishbone bus bundle used for register access.
//   master : drives cyc/stb/we/sel/adr/dat_ms, receives dat_sm/ack/err
//   slave  : the reverse
interface wb_bus_t;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
    input  wb_dat_sm, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
    output wb_dat_sm, wb_ack, wb_err
  );
endinterface

// File: rtl/irq_ctrl_incl.sv
// Shared definitions for the interrupt controller.
//   - Register indices as selected by wb_adr[3:2].
//   - FSM state encodings.
//   - Width of a source ID (ID 0 means "no source").
`ifndef IRQ_CTRL_INCL_SV
`define IRQ_CTRL_INCL_SV

`define IRQC_REG_PENDING 2'd0
`define IRQC_REG_ENABLE  2'd1
`define IRQC_REG_MODE    2'd2
`define IRQC_REG_CLAIM   2'd3

`define IRQC_IDLE        1'b0
`define IRQC_IN_SERVICE  1'b1

`define IRQC_ID_W        5

`endif

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
//   req : one bit per source
//   id  : index+1 of the lowest set bit of req, 0 when req is all zero
`include "irq_ctrl_incl.sv"

module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0]      req,
  output logic [`IRQC_ID_W-1:0] id
);

  localparam int ID_W = `IRQC_ID_W;

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller.
//   clk       : system clock
//   rstn_i    : asynchronous active-low reset
//   irq_src_i : N_SRC request lines, synchronous to clk
//   irq_o     : registered interrupt to the core
//   irq_id_o  : registered ID of the winning pending+enabled source (0 = none)
//   wb_bus    : Wishbone slave; registers PENDING (W1C), ENABLE, MODE, CLAIM
// Servicing is serialised: a CLAIM read moves to IN_SERVICE, a CLAIM write of
// the claimed ID returns to IDLE. No nesting.
`include "irq_ctrl_incl.sv"

module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic [N_SRC-1:0]      irq_src_i,
  output logic                  irq_o,
  output logic [`IRQC_ID_W-1:0] irq_id_o,
  wb_bus_t.slave                wb_bus
);

  localparam int ID_W = `IRQC_ID_W;

  typedef enum logic {
    IDLE       = `IRQC_IDLE,
    IN_SERVICE = `IRQC_IN_SERVICE
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   claimed_id, claimed_id_nxt;
  logic [N_SRC-1:0]  src_q, pending, pending_nxt, enable, mode;
  logic [N_SRC-1:0]  set_vec, w1c_vec, claim_clr;
  logic [ID_W-1:0]   sel_id;
  logic              any_active;

  // ---------------- Wishbone decode ----------------
  logic        access, bad_adr, rd, wr;
  logic [1:0]  reg_idx;
  logic [31:0] byte_mask, wdata_m, rdata;

  assign access  = wb_bus.wb_cyc && wb_bus.wb_stb;
  assign bad_adr = wb_bus.wb_adr > 32'hC;
  assign rd      = access && !bad_adr && !wb_bus.wb_we;
  assign wr      = access && !bad_adr &&  wb_bus.wb_we;
  assign reg_idx = wb_bus.wb_adr[3:2];

  assign byte_mask = {{8{wb_bus.wb_sel[3]}}, {8{wb_bus.wb_sel[2]}},
                      {8{wb_bus.wb_sel[1]}}, {8{wb_bus.wb_sel[0]}}};
  assign wdata_m   = wb_bus.wb_dat_ms & byte_mask;

  assign wb_bus.wb_ack    = access;
  assign wb_bus.wb_err    = access && bad_adr;
  assign wb_bus.wb_dat_sm = rd ? rdata : 32'h0;

  logic claim_rd, claim_wr, claim_take;
  assign claim_rd = rd && (reg_idx == `IRQC_REG_CLAIM);
  assign claim_wr = wr && (reg_idx == `IRQC_REG_CLAIM);

  // ---------------- Selection ----------------
  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req (pending & enable),
    .id  (sel_id)
  );

  assign any_active = |(pending & enable);
  assign claim_take = (state == IDLE) && claim_rd && (sel_id != '0);

  // ---------------- Capture ----------------
  // Edge-mode sources pend on a 0->1 transition; level-mode sources pend on
  // every cycle they are high. Sets are ORed in after clears so a source
  // event always wins over a W1C or claim-clear of the same bit.
  assign set_vec = irq_src_i & (mode & ~src_q | ~mode);
  assign w1c_vec = (wr && reg_idx == `IRQC_REG_PENDING) ? wdata_m[N_SRC-1:0] : '0;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    claim_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_clr[i] = claim_take && (sel_id == ID_W'(i + 1));
    end
  end

  assign pending_nxt = (pending & ~w1c_vec & ~claim_clr) | set_vec;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      src_q   <= '0;
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      src_q   <= irq_src_i;
      pending <= pending_nxt;
      if (wr && reg_idx == `IRQC_REG_ENABLE)
        enable <= (enable & ~byte_mask[N_SRC-1:0]) | wdata_m[N_SRC-1:0];
      if (wr && reg_idx == `IRQC_REG_MODE)
        mode <= (mode & ~byte_mask[N_SRC-1:0]) | wdata_m[N_SRC-1:0];
    end
  end

  // ---------------- Read mux ----------------
  always_comb begin
    rdata = '0;
    case (reg_idx)
      `IRQC_REG_PENDING: rdata[N_SRC-1:0] = pending;
      `IRQC_REG_ENABLE:  rdata[N_SRC-1:0] = enable;
      `IRQC_REG_MODE:    rdata[N_SRC-1:0] = mode;
      `IRQC_REG_CLAIM:   rdata[ID_W-1:0]  = (state == IDLE) ? sel_id : '0;
      default:           rdata = '0;
    endcase
  end

  // ---------------- Claim/complete FSM ----------------
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      claimed_id <= '0;
    end else begin
      state      <= state_nxt;
      claimed_id <= claimed_id_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    claimed_id_nxt = claimed_id;
    case (state)
      IDLE: begin
        if (claim_take) begin
          state_nxt      = IN_SERVICE;
          claimed_id_nxt = sel_id;
        end
      end
      IN_SERVICE: begin
        if (claim_wr && wb_bus.wb_dat_ms[ID_W-1:0] == claimed_id)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- Outputs ----------------
  // The claim read itself already drops the request so the core never sees
  // a stale interrupt in the cycle after claiming.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      irq_o    <= (state == IDLE) && !claim_take && any_active;
      irq_id_o <= ((state == IDLE) && !claim_take) ? sel_id : '0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: one task per feature, inline comparisons.
module tb_irq_ctrl;

  localparam int N_SRC = 8;
  localparam logic [31:0] A_PEND = 32'h0, A_EN = 32'h4, A_MODE = 32'h8, A_CLAIM = 32'hC;

  logic             clk = 1'b0;
  logic             rstn_i = 1'b0;
  logic [N_SRC-1:0] irq_src_i = '0;
  logic             irq_o;
  logic [4:0]       irq_id_o;

  wb_bus_t wb ();

  irq_ctrl #(.N_SRC(N_SRC)) dut (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .irq_src_i (irq_src_i),
    .irq_o     (irq_o),
    .irq_id_o  (irq_id_o),
    .wb_bus    (wb)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_data;
  logic        rd_ack, rd_err;

  // Bus cycle: drive at the falling edge, sample combinational response 1ns
  // later, let the rising edge commit, release 1ns after it.
  task automatic bus_read(input logic [31:0] a);
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b0;
    wb.wb_adr = a; wb.wb_sel = 4'hF; wb.wb_dat_ms = '0;
    #1;
    rd_data = wb.wb_dat_sm; rd_ack = wb.wb_ack; rd_err = wb.wb_err;
    @(posedge clk); #1;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1;
    wb.wb_adr = a; wb.wb_sel = s; wb.wb_dat_ms = d;
    #1;
    rd_ack = wb.wb_ack; rd_err = wb.wb_err;
    @(posedge clk); #1;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] v);
    @(negedge clk); irq_src_i = v;
    @(posedge clk); #1; irq_src_i = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    cycles(2);
    chk32("reset_irq_o", {31'b0, irq_o}, 32'h0);
    chk32("reset_irq_id", {27'b0, irq_id_o}, 32'h0);
    @(negedge clk); rstn_i = 1'b1;
    bus_read(A_PEND);  chk32("reset_pending", rd_data, 32'h0);
    bus_read(A_EN);    chk32("reset_enable", rd_data, 32'h0);
    bus_read(A_MODE);  chk32("reset_mode", rd_data, 32'h0);
    bus_read(A_CLAIM); chk32("reset_claim", rd_data, 32'h0);
  endtask

  task automatic test_enable;
    bus_write(A_EN, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_EN); chk32("enable_upper_bits_zero", rd_data, 32'hFF);
    bus_write(A_EN, 32'h0000_0000, 4'hE);
    bus_read(A_EN); chk32("enable_sel_masked", rd_data, 32'hFF);
    bus_write(A_EN, 32'h03, 4'hF);
    bus_write(A_MODE, 32'h03, 4'hF);
    pulse(8'h02);
    chk32("enable_irq_not_yet", {31'b0, irq_o}, 32'h0);
    bus_read(A_PEND); chk32("enable_pending", rd_data, 32'h2);
    chk32("enable_irq_o", {31'b0, irq_o}, 32'h1);
    chk32("enable_irq_id", {27'b0, irq_id_o}, 32'h2);
    bus_write(A_PEND, 32'hFF, 4'hF);
    cycles(1);
    chk32("w1c_irq_drops", {31'b0, irq_o}, 32'h0);
  endtask

  task automatic test_claim_complete;
    pulse(8'h03);
    cycles(1);
    chk32("claim_irq_id_before", {27'b0, irq_id_o}, 32'h1);
    bus_read(A_CLAIM); chk32("claim_first", rd_data, 32'h1);
    chk32("claim_irq_low", {31'b0, irq_o}, 32'h0);
    chk32("claim_id_low", {27'b0, irq_id_o}, 32'h0);
    bus_read(A_PEND);  chk32("claim_pending_after", rd_data, 32'h2);
    bus_read(A_CLAIM); chk32("claim_in_service", rd_data, 32'h0);
    chk32("claim_irq_still_low", {31'b0, irq_o}, 32'h0);
    bus_write(A_CLAIM, 32'h1, 4'hF);
    chk32("complete_irq_edge", {31'b0, irq_o}, 32'h0);
    cycles(1);
    chk32("complete_irq_back", {31'b0, irq_o}, 32'h1);
    chk32("complete_id_back", {27'b0, irq_id_o}, 32'h2);
    bus_read(A_CLAIM); chk32("claim_second", rd_data, 32'h2);
    bus_write(A_CLAIM, 32'h2, 4'hF);
    bus_read(A_PEND);  chk32("claim_all_clear", rd_data, 32'h0);
  endtask

  task automatic test_masking;
    bus_write(A_EN, 32'h0, 4'hF);
    pulse(8'h08);
    cycles(2);
    chk32("mask_irq_off", {31'b0, irq_o}, 32'h0);
    bus_read(A_PEND); chk32("mask_pending", rd_data, 32'h8);
    bus_write(A_EN, 32'h8, 4'hF);
    chk32("unmask_irq_edge", {31'b0, irq_o}, 32'h0);
    cycles(1);
    chk32("unmask_irq_on", {31'b0, irq_o}, 32'h1);
    chk32("unmask_id", {27'b0, irq_id_o}, 32'h4);
    bus_read(A_CLAIM); chk32("unmask_claim", rd_data, 32'h4);
    bus_write(A_CLAIM, 32'h4, 4'hF);
  endtask

  task automatic test_collisions;
    // Level mode (MODE bit 2 = 0): a held source re-pends over W1C.
    @(negedge clk); irq_src_i = 8'h04;
    cycles(2);
    bus_write(A_PEND, 32'h4, 4'hF);
    bus_read(A_PEND); chk32("level_w1c_loses", rd_data, 32'h4);
    @(negedge clk); irq_src_i = '0;
    bus_write(A_PEND, 32'h4, 4'h2);
    bus_read(A_PEND); chk32("w1c_wrong_byte", rd_data, 32'h4);
    bus_write(A_PEND, 32'h4, 4'h1);
    bus_read(A_PEND); chk32("level_w1c_clears", rd_data, 32'h0);
    // Edge mode: a rising edge in the same cycle as W1C keeps the bit.
    bus_write(A_MODE, 32'h7, 4'hF);
    @(negedge clk);
    irq_src_i = 8'h04;
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1;
    wb.wb_adr = A_PEND; wb.wb_sel = 4'hF; wb.wb_dat_ms = 32'h4;
    @(posedge clk); #1;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    cycles(1);
    bus_read(A_PEND); chk32("edge_w1c_loses", rd_data, 32'h4);
    @(negedge clk); irq_src_i = '0;
    bus_write(A_PEND, 32'h4, 4'hF);
    bus_read(A_PEND); chk32("edge_w1c_clears", rd_data, 32'h0);
  endtask

  task automatic test_errors;
    bus_read(32'h10);
    chk32("err_ack", {31'b0, rd_ack}, 32'h1);
    chk32("err_err", {31'b0, rd_err}, 32'h1);
    chk32("err_rdata", rd_data, 32'h0);
    bus_write(32'h14, 32'hFF, 4'hF);
    bus_read(A_EN);
    chk32("err_no_write", rd_data, 32'h8);
    chk32("ok_ack", {31'b0, rd_ack}, 32'h1);
    chk32("ok_no_err", {31'b0, rd_err}, 32'h0);
    // Mismatched complete leaves the FSM in service.
    bus_write(A_EN, 32'h3, 4'hF);
    pulse(8'h01);
    cycles(1);
    bus_read(A_CLAIM); chk32("mismatch_claim", rd_data, 32'h1);
    pulse(8'h02);
    bus_write(A_CLAIM, 32'h5, 4'hF);
    cycles(2);
    chk32("mismatch_irq_low", {31'b0, irq_o}, 32'h0);
    bus_read(A_CLAIM); chk32("mismatch_still_service", rd_data, 32'h0);
    bus_write(A_CLAIM, 32'h1, 4'hF);
    cycles(1);
    chk32("match_irq_high", {31'b0, irq_o}, 32'h1);
    chk32("match_id", {27'b0, irq_id_o}, 32'h2);
    bus_read(A_CLAIM); chk32("match_claim2", rd_data, 32'h2);
    bus_write(A_CLAIM, 32'h2, 4'hF);
  endtask

  task automatic test_reset_mid_service;
    bus_write(A_EN, 32'hFF, 4'hF);
    bus_write(A_MODE, 32'hFF, 4'hF);
    pulse(8'hFF);
    cycles(1);
    bus_read(A_CLAIM); chk32("rst_pre_claim", rd_data, 32'h1);
    pulse(8'hFF);
    bus_read(A_PEND); chk32("rst_pre_pending", rd_data, 32'hFF);
    @(negedge clk); rstn_i = 1'b0;
    #1;
    chk32("rst_irq_o", {31'b0, irq_o}, 32'h0);
    @(negedge clk); rstn_i = 1'b1;
    bus_read(A_PEND);  chk32("rst_pending_clear", rd_data, 32'h0);
    bus_read(A_CLAIM); chk32("rst_claim_zero", rd_data, 32'h0);
    bus_write(A_EN, 32'h1, 4'hF);
    pulse(8'h01);
    cycles(1);
    chk32("rst_back_idle_irq", {31'b0, irq_o}, 32'h1);
  endtask

  initial begin
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    wb.wb_sel = 4'h0; wb.wb_adr = '0; wb.wb_dat_ms = '0;
    test_reset;
    test_enable;
    test_claim_complete;
    test_masking;
    test_collisions;
    test_errors;
    test_reset_mid_service;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1);
  end

endmodule
